// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART Rx frame controller: one-hot state
//   encodings, parity mode codes, the minimum data length and small helpers
//   for length clamping and parity evaluation.
package uart_pkg;

  localparam int STATE_W       = 5;
  localparam int CNT_W         = 4;
  localparam int MIN_DATA_BITS = 5;

  // One-hot frame states; the encoding is visible on State_o.
  typedef enum logic [STATE_W-1:0] {
    ST_INTERVAL = 5'b00001,
    ST_START    = 5'b00010,
    ST_DATA     = 5'b00100,
    ST_PARITY   = 5'b01000,
    ST_STOP     = 5'b10000
  } state_e;

  // Parity mode codes; 5..7 behave as "none".
  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  // Clamp a requested data length into MIN_DATA_BITS..max_bits.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] req,
                                                 input int max_bits);
    logic [CNT_W-1:0] len;
    len = req;
    if (int'(req) < MIN_DATA_BITS) begin
      len = CNT_W'(MIN_DATA_BITS);
    end else if (int'(req) > max_bits) begin
      len = CNT_W'(max_bits);
    end
    return len;
  endfunction

  function automatic logic parity_enabled(input logic [2:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
           (mode == PAR_MARK) || (mode == PAR_SPACE);
  endfunction

  // Expected parity bit given the XOR of all data bits received.
  function automatic logic parity_expected(input logic [2:0] mode, input logic acc);
    logic exp_bit;
    case (mode)
      PAR_EVEN: exp_bit = acc;
      PAR_ODD:  exp_bit = ~acc;
      PAR_MARK: exp_bit = 1'b1;
      default:  exp_bit = 1'b0;
    endcase
    return exp_bit;
  endfunction

endpackage

// File: rtl/tmr_vote.sv
// tmr_vote
//   Bitwise 2-of-3 majority voter with a disagreement flag.
//   Ports:
//     a_i, b_i, c_i  replica values (W bits each)
//     voted_o        bitwise majority (or a_i when ENABLE = 0)
//     mismatch_o     high when any replica differs from another
module tmr_vote #(
  parameter int W      = 1,
  parameter int ENABLE = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] voted_o,
  output logic         mismatch_o
);

  generate
    if (ENABLE != 0) begin : g_vote
      assign voted_o    = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
      assign mismatch_o = (a_i != b_i) || (b_i != c_i);
    end else begin : g_pass
      logic unused_replicas;
      assign unused_replicas = ^{b_i, c_i};
      assign voted_o         = a_i;
      assign mismatch_o      = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/uart_rx_fsm_cfg.sv
// uart_rx_fsm_cfg
//   Rx frame controller between the Rx shift register and the control
//   module. Walks START / DATA / optional PARITY / STOP, assembles the data
//   word LSB first, and reports parity, framing and break conditions. A
//   watchdog on AcqSig_i aborts frames whose bit pulses stop arriving. State
//   and bit counter are optionally held in three replicas with voting.
//   Ports:
//     clk, rst        clock; synchronous active-low reset
//     Rx_Synch_i      start-of-frame pulse
//     Bit_Synch_i     bit-complete pulse, Bit_Value_i valid with it
//     AcqSig_i        16x baud tick feeding the watchdog
//     DataBits_i      data length request (clamped to 5..MAX_DATA_BITS)
//     ParityMode_i    0 none, 1 even, 2 odd, 3 mark, 4 space, 5-7 none
//     StopBits_i      0 one stop bit, 1 two stop bits
//     State_o         one-hot frame state
//     BitCounter_o    data index in DATA, stop index in STOP, else 0
//     Data_o          last completed word, zero-extended
//     DataValid_o     one-cycle frame-complete pulse
//     ParityErr_o, FrameErr_o, Break_o   flags qualified by DataValid_o
//     Timeout_o       one-cycle watchdog abort pulse
//     TmrMismatch_o   one-cycle replica disagreement pulse
module uart_rx_fsm_cfg
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int TMR_ENABLE    = 1,
  parameter int WDT_LIMIT     = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Rx_Synch_i,
  input  logic                     Bit_Synch_i,
  input  logic                     Bit_Value_i,
  input  logic                     AcqSig_i,
  input  logic [3:0]               DataBits_i,
  input  logic [2:0]               ParityMode_i,
  input  logic                     StopBits_i,
  output logic [4:0]               State_o,
  output logic [3:0]               BitCounter_o,
  output logic [MAX_DATA_BITS-1:0] Data_o,
  output logic                     DataValid_o,
  output logic                     ParityErr_o,
  output logic                     FrameErr_o,
  output logic                     Break_o,
  output logic                     Timeout_o,
  output logic                     TmrMismatch_o
);

  localparam int WDT_W = $clog2(WDT_LIMIT + 1);

  // State / counter replicas and their voted values
  logic [STATE_W-1:0] state_a_q, state_b_q, state_c_q, state_v;
  logic [CNT_W-1:0]   cnt_a_q, cnt_b_q, cnt_c_q, cnt_v;
  logic               state_mm, cnt_mm;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_d;

  // Frame configuration latched at Rx_Synch_i
  logic [CNT_W-1:0] len_q, len_d;
  logic [2:0]       pmode_q, pmode_d;
  logic             stop2_q, stop2_d;

  // Per-frame accumulators
  logic [MAX_DATA_BITS-1:0] buf_q, buf_d;
  logic                     acc_q, acc_d;       // XOR of data bits
  logic                     pe_acc_q, pe_acc_d;
  logic                     fe_acc_q, fe_acc_d;
  logic                     any_one_q, any_one_d; // any 1 seen after start
  logic [WDT_W-1:0]         wdt_q, wdt_d;

  // Registered outputs
  logic [MAX_DATA_BITS-1:0] data_q, data_d;
  logic data_valid_q, data_valid_d;
  logic parity_err_q, parity_err_d;
  logic frame_err_q, frame_err_d;
  logic break_q, break_d;
  logic timeout_q, timeout_d;
  logic tmr_mm_q, tmr_mm_d;

  logic in_frame;

  tmr_vote #(.W(STATE_W), .ENABLE(TMR_ENABLE)) u_state_vote (
    .a_i        (state_a_q),
    .b_i        (state_b_q),
    .c_i        (state_c_q),
    .voted_o    (state_v),
    .mismatch_o (state_mm)
  );

  tmr_vote #(.W(CNT_W), .ENABLE(TMR_ENABLE)) u_cnt_vote (
    .a_i        (cnt_a_q),
    .b_i        (cnt_b_q),
    .c_i        (cnt_c_q),
    .voted_o    (cnt_v),
    .mismatch_o (cnt_mm)
  );

  always_comb begin
    state_d      = ST_INTERVAL;
    cnt_d        = cnt_v;
    len_d        = len_q;
    pmode_d      = pmode_q;
    stop2_d      = stop2_q;
    buf_d        = buf_q;
    acc_d        = acc_q;
    pe_acc_d     = pe_acc_q;
    fe_acc_d     = fe_acc_q;
    any_one_d    = any_one_q;
    wdt_d        = wdt_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    break_d      = 1'b0;
    timeout_d    = 1'b0;
    tmr_mm_d     = state_mm | cnt_mm;
    in_frame     = 1'b1;

    case (state_v)
      ST_INTERVAL: begin
        in_frame = 1'b0;
        cnt_d    = '0;
        wdt_d    = '0;
        if (Rx_Synch_i) begin
          state_d   = ST_START;
          len_d     = clamp_len(DataBits_i, MAX_DATA_BITS);
          pmode_d   = ParityMode_i;
          stop2_d   = StopBits_i;
          buf_d     = '0;
          acc_d     = 1'b0;
          pe_acc_d  = 1'b0;
          fe_acc_d  = 1'b0;
          any_one_d = 1'b0;
        end
      end

      ST_START: begin
        state_d = ST_START;
        if (Bit_Synch_i) begin
          // A high start sample is a glitch: drop back silently.
          state_d = Bit_Value_i ? ST_INTERVAL : ST_DATA;
          cnt_d   = '0;
        end
      end

      ST_DATA: begin
        state_d = ST_DATA;
        if (Bit_Synch_i) begin
          for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (cnt_v == CNT_W'(i)) buf_d[i] = Bit_Value_i;
          end
          acc_d     = acc_q ^ Bit_Value_i;
          any_one_d = any_one_q | Bit_Value_i;
          if (cnt_v == len_q - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = parity_enabled(pmode_q) ? ST_PARITY : ST_STOP;
          end else begin
            cnt_d = cnt_v + CNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        state_d = ST_PARITY;
        if (Bit_Synch_i) begin
          pe_acc_d  = Bit_Value_i != parity_expected(pmode_q, acc_q);
          any_one_d = any_one_q | Bit_Value_i;
          state_d   = ST_STOP;
          cnt_d     = '0;
        end
      end

      ST_STOP: begin
        state_d = ST_STOP;
        if (Bit_Synch_i) begin
          fe_acc_d  = fe_acc_q | ~Bit_Value_i;
          any_one_d = any_one_q | Bit_Value_i;
          if (cnt_v == {{(CNT_W-1){1'b0}}, stop2_q}) begin
            // Last stop bit: publish the word and flags for one cycle.
            state_d      = ST_INTERVAL;
            cnt_d        = '0;
            data_d       = buf_q;
            data_valid_d = 1'b1;
            parity_err_d = pe_acc_q;
            frame_err_d  = fe_acc_q | ~Bit_Value_i;
            break_d      = ~(any_one_q | Bit_Value_i);
          end else begin
            cnt_d = cnt_v + CNT_W'(1);
          end
        end
      end

      default: begin
        // Voted state is not one-hot: recover to idle and report it.
        in_frame = 1'b0;
        cnt_d    = '0;
        wdt_d    = '0;
        tmr_mm_d = 1'b1;
      end
    endcase

    // Watchdog; a Bit_Synch_i in the same cycle as the limit tick wins.
    if (in_frame) begin
      if (Bit_Synch_i) begin
        wdt_d = '0;
      end else if (AcqSig_i) begin
        if (wdt_q == WDT_W'(WDT_LIMIT - 1)) begin
          state_d   = ST_INTERVAL;
          cnt_d     = '0;
          wdt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          wdt_d = wdt_q + WDT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_a_q    <= ST_INTERVAL;
      state_b_q    <= ST_INTERVAL;
      state_c_q    <= ST_INTERVAL;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      cnt_c_q      <= '0;
      len_q        <= '0;
      pmode_q      <= '0;
      stop2_q      <= 1'b0;
      buf_q        <= '0;
      acc_q        <= 1'b0;
      pe_acc_q     <= 1'b0;
      fe_acc_q     <= 1'b0;
      any_one_q    <= 1'b0;
      wdt_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
      timeout_q    <= 1'b0;
      tmr_mm_q     <= 1'b0;
    end else begin
      // Every replica reloads from the single voted next value.
      state_a_q    <= state_d;
      state_b_q    <= state_d;
      state_c_q    <= state_d;
      cnt_a_q      <= cnt_d;
      cnt_b_q      <= cnt_d;
      cnt_c_q      <= cnt_d;
      len_q        <= len_d;
      pmode_q      <= pmode_d;
      stop2_q      <= stop2_d;
      buf_q        <= buf_d;
      acc_q        <= acc_d;
      pe_acc_q     <= pe_acc_d;
      fe_acc_q     <= fe_acc_d;
      any_one_q    <= any_one_d;
      wdt_q        <= wdt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_q      <= break_d;
      timeout_q    <= timeout_d;
      tmr_mm_q     <= tmr_mm_d;
    end
  end

  assign State_o       = state_v;
  assign BitCounter_o  = ((state_v == ST_DATA) || (state_v == ST_STOP)) ? cnt_v : '0;
  assign Data_o        = data_q;
  assign DataValid_o   = data_valid_q;
  assign ParityErr_o   = parity_err_q;
  assign FrameErr_o    = frame_err_q;
  assign Break_o       = break_q;
  assign Timeout_o     = timeout_q;
  assign TmrMismatch_o = tmr_mm_q;

endmodule

// File: tb/tb_uart_rx_fsm_cfg.sv
// tb_uart_rx_fsm_cfg
//   Directed frames driven bit by bit. Expected results for each frame are
//   derived from the serial bits and configuration with plain arithmetic and
//   queued; a negedge compare process checks every DataValid_o pulse against
//   the queue and Data_o against the last expected word on every cycle.
module tb_uart_rx_fsm_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Rx_Synch_i = 1'b0;
  logic       Bit_Synch_i = 1'b0;
  logic       Bit_Value_i = 1'b1;
  logic       AcqSig_i = 1'b0;
  logic [3:0] DataBits_i = 4'd8;
  logic [2:0] ParityMode_i = 3'd0;
  logic       StopBits_i = 1'b0;
  logic [4:0] State_o;
  logic [3:0] BitCounter_o;
  logic [8:0] Data_o;
  logic       DataValid_o, ParityErr_o, FrameErr_o, Break_o, Timeout_o, TmrMismatch_o;

  always #5 clk = ~clk;

  uart_rx_fsm_cfg #(.MAX_DATA_BITS(9), .TMR_ENABLE(1), .WDT_LIMIT(40)) dut (
    .clk           (clk),
    .rst           (rst),
    .Rx_Synch_i    (Rx_Synch_i),
    .Bit_Synch_i   (Bit_Synch_i),
    .Bit_Value_i   (Bit_Value_i),
    .AcqSig_i      (AcqSig_i),
    .DataBits_i    (DataBits_i),
    .ParityMode_i  (ParityMode_i),
    .StopBits_i    (StopBits_i),
    .State_o       (State_o),
    .BitCounter_o  (BitCounter_o),
    .Data_o        (Data_o),
    .DataValid_o   (DataValid_o),
    .ParityErr_o   (ParityErr_o),
    .FrameErr_o    (FrameErr_o),
    .Break_o       (Break_o),
    .Timeout_o     (Timeout_o),
    .TmrMismatch_o (TmrMismatch_o)
  );

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  exp_t       exp_q[$];
  int         n_total = 0;
  int         n_bad = 0;
  logic [8:0] model_data = '0;
  logic       rst_seen = 1'b0;
  int         timeout_seen = 0;
  int         mm_seen = 0;
  logic [8:0] last_data = '0;
  logic       last_pe = 1'b0, last_fe = 1'b0, last_brk = 1'b0;

  always @(posedge clk) rst_seen <= rst;

  // Compare process
  always @(negedge clk) begin
    if (!rst_seen) begin
      model_data = '0;
      exp_q.delete();
    end else begin
      if (DataValid_o) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid got=1 want=0");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({Data_o, ParityErr_o, FrameErr_o, Break_o} !== {e.data, e.pe, e.fe, e.brk}) begin
            n_bad++;
            $display("FAIL frame_result got data=%h pe=%b fe=%b brk=%b want data=%h pe=%b fe=%b brk=%b",
                     Data_o, ParityErr_o, FrameErr_o, Break_o, e.data, e.pe, e.fe, e.brk);
          end
          model_data = e.data;
        end
        last_data = Data_o;
        last_pe   = ParityErr_o;
        last_fe   = FrameErr_o;
        last_brk  = Break_o;
      end
      n_total++;
      if (Data_o !== model_data) begin
        n_bad++;
        $display("FAIL data_hold got=%h want=%h", Data_o, model_data);
      end
      n_total++;
      if (!$onehot(State_o)) begin
        n_bad++;
        $display("FAIL state_onehot got=%b want=one-hot", State_o);
      end
      if (Timeout_o) timeout_seen++;
      if (TmrMismatch_o) mm_seen++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One serial bit: ticks-1 cycles of AcqSig_i, then AcqSig_i with Bit_Synch_i.
  task automatic send_bit(input logic v, input int ticks);
    for (int k = 1; k < ticks; k++) begin
      AcqSig_i = 1'b1;
      tick();
    end
    AcqSig_i    = 1'b1;
    Bit_Synch_i = 1'b1;
    Bit_Value_i = v;
    tick();
    AcqSig_i    = 1'b0;
    Bit_Synch_i = 1'b0;
    Bit_Value_i = 1'b1;
  endtask

  function automatic int eff_len(input int cfg_bits);
    int len;
    len = cfg_bits;
    if (len < 5) len = 5;
    if (len > 9) len = 9;
    return len;
  endfunction

  // Frame outcome from the serial bits alone.
  function automatic exp_t model(input int cfg_bits, input int pmode, input int stop2,
                                 input logic [8:0] data, input logic pbit, input logic [1:0] stops);
    exp_t e;
    int   mask;
    logic pen, pexp, ones;
    logic [1:0] used;
    mask   = (1 << eff_len(cfg_bits)) - 1;
    e.data = data & mask[8:0];
    ones   = ($countones(e.data) % 2) == 1;
    pen    = (pmode >= 1) && (pmode <= 4);
    case (pmode)
      1:       pexp = ones;
      2:       pexp = !ones;
      3:       pexp = 1'b1;
      default: pexp = 1'b0;
    endcase
    e.pe  = pen && (pbit != pexp);
    used  = (stop2 != 0) ? stops : {1'b1, stops[0]};
    e.fe  = used != 2'b11;
    e.brk = (e.data == 0) && (!pen || !pbit) && ((stop2 != 0) ? (stops == 2'b00) : !stops[0]);
    return e;
  endfunction

  task automatic send_frame(input string name, input int cfg_bits, input int pmode, input int stop2,
                            input logic [8:0] data, input logic pbit, input logic [1:0] stops,
                            input int long_idx, input int tmr_idx);
    exp_t e;
    int   len;
    logic pen;
    e   = model(cfg_bits, pmode, stop2, data, pbit, stops);
    len = eff_len(cfg_bits);
    pen = (pmode >= 1) && (pmode <= 4);
    DataBits_i   = 4'(cfg_bits);
    ParityMode_i = 3'(pmode);
    StopBits_i   = 1'(stop2);
    Rx_Synch_i   = 1'b1;
    tick();
    Rx_Synch_i   = 1'b0;
    // Configuration changes mid-frame must be ignored.
    DataBits_i   = 4'd6;
    ParityMode_i = (pmode == 0) ? 3'd1 : 3'd0;
    StopBits_i   = ~StopBits_i;
    check({name, ":start_state"}, 32'(State_o), 32'h02);
    send_bit(1'b0, 16);
    for (int i = 0; i < len; i++) begin
      if (i == tmr_idx) begin
        @(negedge clk);
        force dut.state_b_q = 5'b01000;
        @(negedge clk);
        release dut.state_b_q;
        tick();
      end
      check($sformatf("%s:data_state%0d", name, i), 32'(State_o), 32'h04);
      check($sformatf("%s:data_cnt%0d", name, i), 32'(BitCounter_o), 32'(i));
      send_bit(data[i], (i == long_idx) ? 40 : 16);
    end
    if (pen) begin
      check({name, ":parity_state"}, 32'(State_o), 32'h08);
      send_bit(pbit, 16);
    end
    for (int s = 0; s <= stop2; s++) begin
      check($sformatf("%s:stop_state%0d", name, s), 32'(State_o), 32'h10);
      check($sformatf("%s:stop_cnt%0d", name, s), 32'(BitCounter_o), 32'(s));
      if (s == stop2) exp_q.push_back(e);
      send_bit(stops[s], 16);
    end
    tick();
    tick();
    tick();
    check({name, ":valid_seen"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check({name, ":idle_state"}, 32'(State_o), 32'h01);
    $display("frame %s: bits=%0d par=%0d stop2=%0d data=%h -> Data_o=%h pe=%b fe=%b brk=%b",
             name, cfg_bits, pmode, stop2, data, last_data, last_pe, last_fe, last_brk);
  endtask

  initial begin
    int t0, m0;
    #1_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t0, m0;
    rst = 1'b0;
    repeat (3) tick();
    check("reset:state", 32'(State_o), 32'h01);
    check("reset:cnt", 32'(BitCounter_o), 32'd0);
    check("reset:data", 32'(Data_o), 32'd0);
    check("reset:pulses", 32'({DataValid_o, ParityErr_o, FrameErr_o, Break_o, Timeout_o, TmrMismatch_o}), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // 8N1 0xA5
    send_frame("8N1_A5", 8, 0, 0, 9'h0A5, 1'b0, 2'b11, -1, -1);
    check("8N1_A5:data", 32'(last_data), 32'h0A5);
    check("8N1_A5:flags", 32'({last_pe, last_fe, last_brk}), 32'd0);

    // 7E2 0x41: two ones, even parity bit should be 0
    send_frame("7E2_p1", 7, 1, 1, 9'h041, 1'b1, 2'b11, -1, -1);
    check("7E2_p1:pe", 32'(last_pe), 32'd1);
    send_frame("7E2_p0", 7, 1, 1, 9'h041, 1'b0, 2'b11, -1, -1);
    check("7E2_p0:pe", 32'(last_pe), 32'd0);

    // 9O1 0x1FF: nine ones, odd parity bit should be 0
    send_frame("9O1_ok", 9, 2, 0, 9'h1FF, 1'b0, 2'b11, -1, -1);
    check("9O1_ok:data", 32'(last_data), 32'h1FF);
    check("9O1_ok:flags", 32'({last_pe, last_fe, last_brk}), 32'd0);
    send_frame("9O1_stop0", 9, 2, 0, 9'h1FF, 1'b0, 2'b10, -1, -1);
    check("9O1_stop0:fe", 32'(last_fe), 32'd1);

    // 8N1 break
    send_frame("8N1_break", 8, 0, 0, 9'h000, 1'b0, 2'b00, -1, -1);
    check("8N1_break:flags", 32'({last_pe, last_fe, last_brk}), 32'b011);
    check("8N1_break:data", 32'(last_data), 32'd0);

    // False start: no pulses expected, back to idle
    Rx_Synch_i = 1'b1;
    tick();
    Rx_Synch_i = 1'b0;
    send_bit(1'b1, 16);
    tick();
    check("false_start:state", 32'(State_o), 32'h01);
    $display("frame false_start: start sampled 1 -> state=%b", State_o);

    // Stall: 39 ticks is fine, the 40th aborts
    send_frame("8N1_3C", 8, 0, 0, 9'h03C, 1'b0, 2'b11, -1, -1);
    t0 = timeout_seen;
    DataBits_i = 4'd8; ParityMode_i = 3'd0; StopBits_i = 1'b0;
    Rx_Synch_i = 1'b1;
    tick();
    Rx_Synch_i = 1'b0;
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 16);
    for (int i = 0; i < 39; i++) begin
      AcqSig_i = 1'b1;
      tick();
    end
    AcqSig_i = 1'b0;
    tick();
    tick();
    check("stall:no_early_timeout", 32'(timeout_seen), 32'(t0));
    check("stall:still_data", 32'(State_o), 32'h04);
    AcqSig_i = 1'b1;
    tick();
    AcqSig_i = 1'b0;
    tick();
    tick();
    check("stall:timeout_pulse", 32'(timeout_seen), 32'(t0 + 1));
    check("stall:state", 32'(State_o), 32'h01);
    check("stall:data_kept", 32'(Data_o), 32'h03C);
    $display("frame stall: timeout=%0d data=%h", timeout_seen - t0, Data_o);

    // Bit_Synch_i on the limit tick wins
    t0 = timeout_seen;
    send_frame("8N1_5A_long", 8, 0, 0, 9'h05A, 1'b0, 2'b11, 3, -1);
    check("long_bit:no_timeout", 32'(timeout_seen), 32'(t0));

    // Length clamping, mark and space parity
    send_frame("clamp_lo", 3, 0, 0, 9'h1F5, 1'b0, 2'b11, -1, -1);
    check("clamp_lo:data", 32'(last_data), 32'h015);
    send_frame("clamp_hi", 12, 1, 0, 9'h155, 1'b1, 2'b11, -1, -1);
    check("clamp_hi:data", 32'(last_data), 32'h155);
    send_frame("8M1", 8, 3, 0, 9'h000, 1'b0, 2'b11, -1, -1);
    check("8M1:pe", 32'(last_pe), 32'd1);
    send_frame("8S1", 8, 4, 0, 9'h080, 1'b0, 2'b11, -1, -1);
    check("8S1:pe", 32'(last_pe), 32'd0);

    // Corrupt replica B mid-DATA
    check("tmr:quiet_before", 32'(mm_seen), 32'd0);
    m0 = mm_seen;
    send_frame("tmr_C3", 8, 0, 0, 9'h0C3, 1'b0, 2'b11, -1, 4);
    check("tmr:pulse_seen", 32'((mm_seen - m0 >= 1) && (mm_seen - m0 <= 2)), 32'd1);
    check("tmr:data", 32'(last_data), 32'h0C3);
    m0 = mm_seen;

    // Reset mid-frame
    DataBits_i = 4'd8; ParityMode_i = 3'd0; StopBits_i = 1'b0;
    Rx_Synch_i = 1'b1;
    tick();
    Rx_Synch_i = 1'b0;
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b1, 16);
    rst = 1'b0;
    tick();
    tick();
    check("midreset:state", 32'(State_o), 32'h01);
    check("midreset:cnt", 32'(BitCounter_o), 32'd0);
    check("midreset:data", 32'(Data_o), 32'd0);
    rst = 1'b1;
    tick();
    tick();
    $display("frame midreset: state=%b data=%h", State_o, Data_o);
    send_frame("8N1_81", 8, 0, 0, 9'h081, 1'b0, 2'b11, -1, -1);
    check("8N1_81:data", 32'(last_data), 32'h081);
    check("tmr:quiet_after", 32'(mm_seen), 32'(m0));
    check("timeout_total", 32'(timeout_seen), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
